// File: rtl/irq_sched.sv
// Six-source interrupt scheduler. Per-source edge/level capture, masking and
// fixed-priority nesting. The selected source goes to the CPU as a registered one-hot vector.

module irq_sched_src (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  input  logic mode,
  input  logic mode_nxt,
  input  logic clr,
  output logic pend,
  output logic pe
);
  logic src_q;
  logic set;

  assign set = src & ~src_q;
  assign pe  = mode ? pend : src;

  // A new edge beats a same-cycle clear. Leaving edge mode drops any capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      src_q <= src;
      pend  <= mode & mode_nxt & (set | (pend & ~clr));
    end
  end
endmodule

module irq_sched #(
  parameter int NSRC = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:2]  addr,
  input  logic        we,
  input  logic        rd_en,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  input  logic [5:0]  src,
  output logic [5:0]  cpu_int
);
  logic [NSRC-1:0] mask, mode, isr, pend, pe, elig, clr, mode_nxt;
  logic [NSRC-1:0] claim_oh, eoi_oh, w1c;
  logic [2:0]      w;
  logic            valid, claim;
  logic            unused_wd;

  assign unused_wd = ^wd[31:6];

  assign mode_nxt = (we && addr == 2'd2) ? wd[NSRC-1:0] : mode;
  assign w1c      = (we && addr == 2'd1) ? wd[NSRC-1:0] : '0;
  assign claim    = rd_en && addr == 2'd3 && valid;
  assign claim_oh = claim ? (NSRC'(1) << w) : '0;
  assign eoi_oh   = (we && addr == 2'd3 && wd[2:0] < 3'(NSRC)) ? (NSRC'(1) << wd[2:0]) : '0;
  assign clr      = w1c | claim_oh;

  generate
    for (genvar i = 0; i < NSRC; i++) begin : g_src
      irq_sched_src u_src (
        .clk      (clk),
        .rst_n    (rst_n),
        .src      (src[i]),
        .mode     (mode[i]),
        .mode_nxt (mode_nxt[i]),
        .clr      (clr[i]),
        .pend     (pend[i]),
        .pe       (pe[i])
      );
      // Eligible only if no source at this index or above is in service.
      assign elig[i] = pe[i] & mask[i] & ~(|isr[i:0]);
    end
  endgenerate

  always_comb begin
    valid = 1'b0;
    w     = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        valid = 1'b1;
        w     = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask    <= '0;
      mode    <= '0;
      isr     <= '0;
      cpu_int <= '0;
    end else begin
      if (we && addr == 2'd0) mask <= wd[NSRC-1:0];
      mode    <= mode_nxt;
      // Claim is applied after EOI so that EOI+claim of the same bit stays in service.
      isr     <= (isr & ~eoi_oh) | claim_oh;
      cpu_int <= valid ? (NSRC'(1) << w) : '0;
    end
  end

  always_comb begin
    rd = '0;
    case (addr)
      2'd0: rd[NSRC-1:0] = mask;
      2'd1: rd[NSRC-1:0] = pe;
      2'd2: rd[NSRC-1:0] = mode;
      2'd3: rd = {valid, 28'b0, (valid ? w : 3'd0)};
      default: rd = '0;
    endcase
  end
endmodule

// File: tb/tb_irq_sched.sv
// Randomized and directed bench for irq_sched. A per-cycle behavioural model is
// built from the scheduling rules and compared on cpu_int and rd every cycle.

module tb_irq_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:2]  addr = '0;
  logic        we = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic [5:0]  src = '0;
  logic [5:0]  cpu_int;

  int n_chk = 0;
  int n_err = 0;

  logic [5:0] m_mask, m_mode, m_pend, m_isr, m_srcq, m_cpu;

  irq_sched dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .we      (we),
    .rd_en   (rd_en),
    .wd      (wd),
    .rd      (rd),
    .src     (src),
    .cpu_int (cpu_int)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_mask = '0; m_mode = '0; m_pend = '0; m_isr = '0; m_srcq = '0; m_cpu = '0;
  endfunction

  function automatic bit m_pe(int i);
    return m_mode[i] ? m_pend[i] : src[i];
  endfunction

  // Highest-priority eligible source strictly above the current service level, or -1.
  function automatic int m_winner();
    int lvl = 6;
    for (int i = 0; i < 6; i++)
      if (m_isr[i]) begin lvl = i; break; end
    for (int i = 0; i < lvl; i++)
      if (m_pe(i) && m_mask[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_rd();
    logic [31:0] r = '0;
    int w = m_winner();
    case (addr)
      2'd0: r[5:0] = m_mask;
      2'd1: for (int i = 0; i < 6; i++) r[i] = m_pe(i);
      2'd2: r[5:0] = m_mode;
      default: if (w >= 0) r = 32'h8000_0000 + 32'(w);
    endcase
    return r;
  endfunction

  function automatic void m_step();
    int w = m_winner();
    bit cl = rd_en && addr == 2'd3 && w >= 0;
    logic [5:0] p;
    for (int i = 0; i < 6; i++) begin
      p[i] = 1'b0;
      if (m_mode[i]) begin
        p[i] = m_pend[i];
        if (we && addr == 2'd1 && wd[i]) p[i] = 1'b0;
        if (cl && w == i) p[i] = 1'b0;
        if (src[i] && !m_srcq[i]) p[i] = 1'b1;
      end
      if (we && addr == 2'd2 && !wd[i]) p[i] = 1'b0;
    end
    if (we && addr == 2'd3 && wd[2:0] < 3'd6) m_isr[wd[2:0]] = 1'b0;
    if (cl) m_isr[w] = 1'b1;
    m_cpu = (w >= 0) ? 6'(1 << w) : 6'd0;
    m_pend = p;
    if (we && addr == 2'd0) m_mask = wd[5:0];
    if (we && addr == 2'd2) m_mode = wd[5:0];
    m_srcq = src;
  endfunction

  // One clock: drive at negedge, check combinational/registered outputs, advance the model.
  task automatic cyc(input logic [5:0] s, input logic [1:0] a, input logic w_e,
                     input logic [31:0] d, input logic r_e);
    @(negedge clk);
    src = s; addr = a; we = w_e; wd = d; rd_en = r_e;
    #1;
    chk("cpu_int", {26'b0, cpu_int}, {26'b0, m_cpu});
    chk("rd", rd, m_rd());
    @(posedge clk);
    m_step();
  endtask

  // Look at a register mid-cycle without strobes; the next cyc reapplies inputs.
  task automatic peek(input string tag, input logic [1:0] a, input logic [31:0] exp);
    #2;
    addr = a; we = 1'b0; rd_en = 1'b0;
    #1;
    chk(tag, rd, exp);
  endtask

  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_cpu_int", {26'b0, cpu_int}, 32'h0);
    chk("rst_isr", {26'b0, dut.isr}, 32'h0);
    chk("rst_pend", {26'b0, dut.pend}, 32'h0);
    m_reset();
    src = '0; addr = '0; we = 1'b0; wd = '0; rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    m_reset();
    #12;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      chk("reset_rd", rd, 32'h0);
    end
    chk("reset_cpu_int", {26'b0, cpu_int}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Edge source 2
    cyc(6'h00, 2'd0, 1, 32'h3F, 0);
    cyc(6'h00, 2'd2, 1, 32'h04, 0);
    cyc(6'h04, 2'd0, 0, 0, 0);
    cyc(6'h00, 2'd0, 0, 0, 0);
    #1 chk("edge_cpu_int", {26'b0, cpu_int}, 32'h04);
    peek("edge_claim_rd", 2'd3, 32'h8000_0002);
    cyc(6'h00, 2'd3, 0, 0, 1);
    cyc(6'h00, 2'd0, 0, 0, 0);
    #1 chk("claimed_cpu_int", {26'b0, cpu_int}, 32'h0);
    cyc(6'h00, 2'd3, 1, 32'h2, 0);
    #1 chk("eoi_isr", {26'b0, dut.isr}, 32'h0);

    // Nesting: src4 level held, src1 edge preempts, src5 waits
    cyc(6'h10, 2'd2, 1, 32'h06, 0);
    cyc(6'h10, 2'd0, 0, 0, 0);
    #1 chk("lvl_cpu_int", {26'b0, cpu_int}, 32'h10);
    cyc(6'h10, 2'd3, 0, 0, 1);
    cyc(6'h12, 2'd0, 0, 0, 0);
    cyc(6'h10, 2'd0, 0, 0, 0);
    #1 chk("nest_cpu_int", {26'b0, cpu_int}, 32'h02);
    peek("nest_claim_rd", 2'd3, 32'h8000_0001);
    cyc(6'h10, 2'd3, 0, 0, 1);
    cyc(6'h30, 2'd0, 0, 0, 0);
    cyc(6'h30, 2'd0, 0, 0, 0);
    #1 chk("src5_wait", {26'b0, cpu_int}, 32'h0);
    cyc(6'h30, 2'd3, 1, 32'h1, 0);
    cyc(6'h30, 2'd0, 0, 0, 0);
    #1 chk("src5_still_wait", {26'b0, cpu_int}, 32'h0);
    peek("below_lvl_claim", 2'd3, 32'h0);
    cyc(6'h32, 2'd0, 0, 0, 0);
    cyc(6'h30, 2'd0, 0, 0, 0);
    cyc(6'h30, 2'd3, 0, 0, 1);
    #1 chk("isr_12", {26'b0, dut.isr}, 32'h12);
    mid_reset();

    // Mask and W1C on src3
    cyc(6'h00, 2'd2, 1, 32'h08, 0);
    cyc(6'h08, 2'd0, 0, 0, 0);
    cyc(6'h00, 2'd0, 0, 0, 0);
    peek("masked_pend", 2'd1, 32'h08);
    chk("masked_cpu_int", {26'b0, cpu_int}, 32'h0);
    cyc(6'h00, 2'd0, 1, 32'h08, 0);
    cyc(6'h00, 2'd0, 0, 0, 0);
    #1 chk("unmask_cpu_int", {26'b0, cpu_int}, 32'h08);
    cyc(6'h00, 2'd1, 1, 32'h08, 0);
    peek("w1c_pend", 2'd1, 32'h0);
    cyc(6'h00, 2'd0, 0, 0, 0);
    #1 chk("w1c_cpu_int", {26'b0, cpu_int}, 32'h0);

    // Simultaneous set/clear, EOI 7, claim with nothing pending
    cyc(6'h00, 2'd2, 1, 32'h09, 0);
    cyc(6'h01, 2'd1, 1, 32'h01, 0);
    peek("set_wins_pend", 2'd1, 32'h01);
    cyc(6'h00, 2'd3, 1, 32'h7, 0);
    #1 chk("eoi7_isr", {26'b0, dut.isr}, 32'h0);
    cyc(6'h00, 2'd1, 1, 32'h01, 0);
    peek("empty_claim_rd", 2'd3, 32'h0);
    cyc(6'h00, 2'd3, 0, 0, 1);
    #1 chk("empty_claim_isr", {26'b0, dut.isr}, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] s = src;
      logic [31:0] d = $urandom;
      for (int i = 0; i < 6; i++)
        if ($urandom_range(0, 5) == 0) s[i] = ~s[i];
      if ($urandom_range(0, 3) == 0) d[2:0] = 3'($urandom_range(0, 5));
      cyc(s, 2'($urandom_range(0, 3)), ($urandom_range(0, 6) == 0), d,
          ($urandom_range(0, 2) == 0));
      if (n == 1500) mid_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/irq_sched.md
# irq_sched

Programmable interrupt scheduler placed between the peripheral interrupt lines (coco_timer instances and future devices) and the CPU `HWInt[7:2]` input. It latches or tracks six request sources, applies a per-source mask and trigger mode, and picks the highest-priority eligible source with fixed priority and nesting. It presents that source to the CPU as a registered one-hot vector. The CPU reaches it through the bridge as an ordinary device: it reads a claim register to take an interrupt and writes that register to end service.

## Interface
- NSRC, 6, number of request sources; fixed by the 6-bit `HWInt`; index 0 is highest priority.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- addr  in  [3:2]  register select from bridge: 0 MASK, 1 PEND, 2 MODE, 3 CLAIM.
- we  in  1  write strobe for the selected register.
- rd_en  in  1  read strobe; only matters for CLAIM, where reading has side effects.
- wd  in  32  write data.
- rd  out  32  read data; combinational from current state.
- src  in  [5:0]  raw device interrupt lines, synchronous to clk.
- cpu_int  out  [5:0]  registered one-hot request to CPU `HWInt[7:2]`; zero when nothing is eligible.

## Operation
- State: `mask[5:0]`, `mode[5:0]` (1 = rising-edge, 0 = level), `pend[5:0]`, in-service `isr[5:0]`, `src_q[5:0]` (previous src), `cpu_int`.
- Effective pending: `pe[i] = mode[i] ? pend[i] : src[i]`.
- Edge mode:
  - `pend[i]` sets when `src[i] & ~src_q[i]`.
  - `pend[i]` clears on a PEND write with `wd[i]=1` or on a claim of i.
  - If a set and a clear fall in the same cycle, the set wins.
- Level mode: `pend[i]` is held at 0; PEND writes are ignored for that bit.
- Current level `L` = index of the lowest set `isr` bit, or 6 when `isr == 0`.
- Winner `w` = lowest i such that `pe[i] & mask[i]` and `i < L`. `valid` = a winner exists.
- `cpu_int` is registered each cycle: one-hot at bit w if valid, else 0.
- Register reads (`rd`):
  - MASK: `{26'b0, mask}`.
  - PEND: `{26'b0, pe}`.
  - MODE: `{26'b0, mode}`.
  - CLAIM: `{valid, 28'b0, w[2:0]}`; bits [2:0] are 0 when `!valid`.
- Register writes:
  - MASK: `mask <= wd[5:0]`.
  - MODE: `mode <= wd[5:0]`. Switching a bit from edge to level clears that `pend` bit.
  - PEND: write-1-to-clear on edge-mode bits.
  - CLAIM: end of interrupt (EOI); clears `isr[wd[2:0]]`. Values 6 and 7 are ignored, and so is EOI of a bit that is not in service.
- Claim: `rd_en & addr==3 & valid` sets `isr[w]` and clears `pend[w]` if source w is edge mode. A claim while `!valid` has no effect.
- Claim and EOI in the same cycle: both apply; EOI of w and claim of w leaves `isr[w]=1`.
- Nesting: a higher-priority source (lower index) preempts the current level. Sources at or below the current level wait for EOI.
- A masked source still accumulates `pend`. It becomes eligible as soon as it is unmasked.

## Timing
- Reset (async assert, sync use after deassert): mask, mode, pend, isr, src_q and cpu_int all 0. `rd` then reads 0 for all addresses.
- Edge source: edge of `src` sampled at rising edge k → `pend` set after k → `cpu_int` set after k+1. Latency is 2 cycles.
- Level source: `src` high before edge k → `cpu_int` after k. Latency is 1 cycle.
- Register writes take effect at the edge where `we` is sampled. `cpu_int` reflects the new state one edge later.
- Claim at edge k: `isr`/`pend` update at k; `cpu_int` drops or changes after k+1.
- An edge-mode pulse one cycle wide is captured. Level mode requires `src` held until the claim.
- Reset asserted mid-service clears all state immediately and drops `cpu_int` asynchronously.

## Test plan
- Reset, then read all four addresses → all 0, and `cpu_int = 0`.
- Edge mode on src2, mask = 0x3F, 1-cycle pulse on src2:
  - `cpu_int = 6'b000100` two edges later.
  - CLAIM read → `0x80000002`, and `cpu_int` returns to 0.
  - EOI with `wd = 2` → `isr` clears.
- Nesting:
  - Claim src4 (level, held high).
  - Pulse src1 (edge) → `cpu_int = 6'b000010`; CLAIM read → `0x80000001`.
  - Raise src5 → `cpu_int` stays 0 for src5.
  - EOI 1 → CLAIM returns `0x80000000`-class only for sources below level 4.
- Mask and clear:
  - src3 edge with `mask[3] = 0` → PEND reads 0x8, `cpu_int = 0`.
  - Write MASK 0x08 → `cpu_int = 6'b001000`.
  - Then PEND write 0x08 → PEND reads 0 and `cpu_int` drops.
- Simultaneous events:
  - Edge on src0 in the same cycle as a PEND W1C of bit 0 → `pend[0]` stays 1.
  - EOI of 7 → no state change.
- Claim with nothing pending → read returns 0 and `isr` stays 0. Reset asserted while `isr = 0x12` → `isr`, `cpu_int` and `pend` become 0 immediately.
